cluster_periph_slave_arbiter: RTL and testbench
===============================================

// Module: cluster_periph_slave_arbiter
// PURPOSE
//   Round-robin arbiter that shares one cluster peripheral slave port (EOC, timer, event unit,
//   HWPE, icache ctrl, DMA, decompressor, lockstep, ext) between NB_MST requesters.
//   Masters are the cores and the DMA, all using the req/gnt + r_valid peripheral protocol.
//   Sits between the peripheral interconnect demux and each slave.
//   Tracks outstanding transactions and routes each response back to its originating master.
// PARAMETERS
//   NB_MST      8   number of requesting masters (>=2)
//   ADDR_WIDTH  32  address width
//   DATA_WIDTH  32  data width
//   BE_WIDTH    DATA_WIDTH/8  byte-enable width
//   MAX_OUTST   2   max granted-but-unanswered transactions (power of 2, >=1)
// PORTS
//   clk_i          in   1                      clock
//   rst_i          in   1                      synchronous reset, active-high
//   mst_req_i      in   NB_MST                 per-master request
//   mst_add_i      in   NB_MST x ADDR_WIDTH    per-master address
//   mst_wen_i      in   NB_MST                 per-master write-enable-n (1 = read)
//   mst_wdata_i    in   NB_MST x DATA_WIDTH    per-master write data
//   mst_be_i       in   NB_MST x BE_WIDTH      per-master byte enables
//   mst_gnt_o      out  NB_MST                 per-master grant, one-hot or zero
//   mst_r_valid_o  out  NB_MST                 per-master response valid, one-hot or zero
//   mst_r_rdata_o  out  DATA_WIDTH             response data, broadcast to all masters
//   mst_r_opc_o    out  1                      response error flag, broadcast
//   slv_req_o      out  1                      request to slave
//   slv_add_o / slv_wen_o / slv_wdata_o / slv_be_o   out   selected master's fields
//   slv_gnt_i      in   1                      slave grant
//   slv_r_valid_i  in   1                      slave response valid
//   slv_r_rdata_i  in   DATA_WIDTH             slave response data
//   slv_r_opc_i    in   1                      slave response error
//   err_o          out  1                      sticky protocol error: response with nothing outstanding
// BEHAVIOUR
//   - Reset: rr_ptr=0, lock=0, FIFO empty, err_o=0.
//     All outputs are combinational functions of state and inputs, so after reset:
//     mst_gnt_o=0, mst_r_valid_o=0, slv_req_o=0 unless requests are present.
//   - Selection (unlocked):
//     - Winner is the first requesting master at or after rr_ptr, wrapping from NB_MST-1 to 0.
//     - slv_req_o = |mst_req_i && !fifo_full.
//     - slv_* fields are muxed from the winner. When idle they are driven from master 0 (don't care).
//   - Grant:
//     - mst_gnt_o[w] = slv_req_o & slv_gnt_i, in the same cycle, with zero added latency.
//     - On a grant: push w into the ID FIFO, set rr_ptr = (w+1) mod NB_MST, clear lock.
//   - Stall lock:
//     - If slv_req_o=1 and slv_gnt_i=0, latch lock=1 and lock_idx=w.
//     - While locked, lock_idx is the only candidate, even if other masters raise requests.
//     - rr_ptr is frozen while locked.
//     - If master lock_idx drops its request while locked (protocol violation), clear lock and
//       rearbitrate next cycle.
//   - Full: when the FIFO holds MAX_OUTST entries, slv_req_o=0 and no grants are issued.
//     - This holds even if slv_r_valid_i pops an entry in that same cycle.
//     - The grant resumes the following cycle.
//   - Response:
//     - slv_r_valid_i=1 with FIFO non-empty: mst_r_valid_o[head]=1 and pop, same cycle.
//     - rdata and opc pass through combinationally.
//     - Push and pop in the same cycle are allowed when not full; occupancy stays the same.
//   - Response with FIFO empty: drop it (mst_r_valid_o stays 0) and set err_o=1.
//     err_o is cleared only by reset.
//   - Reset mid-operation: outstanding IDs are discarded. Late slave responses after reset are
//     treated as unexpected (err_o=1).
//   - NB_MST of 1 is not supported; elaboration-time assertion.
// STRUCTURE
//   - Shared cluster package: add typedef periph_req_t {add, wen, wdata, be} and
//     periph_rsp_t {r_valid, r_rdata, r_opc}, plus constant PERIPH_MAX_OUTST=2.
//   - Sub-module periph_id_fifo:
//     - depth MAX_OUTST, width $clog2(NB_MST).
//     - wrapping rd/wr pointers plus a count register.
//     - full/empty flags, synchronous active-high reset.
//   - Top-level logic: rotate-priority RR selection, lock register, output muxes,
//     response demux, err flag.
// TESTING
//   1. Only master 3 requests, slv_gnt_i=1, r_valid one cycle later with rdata=0xCAFE0003
//      -> mst_gnt_o=0x08, then mst_r_valid_o=0x08 with that rdata.
//   2. All 8 masters request every cycle, slv_gnt_i=1, r_valid every cycle
//      -> grants 0,1,2,...,7,0 one per cycle; each response goes to the matching master.
//   3. MAX_OUTST=2, slv_gnt_i=1, no r_valid -> two grants, then slv_req_o=0.
//      Assert r_valid in the full cycle -> no grant that cycle, grant next cycle.
//   4. Master 2 requests with slv_gnt_i=0 for 3 cycles, master 1 raises in cycle 2,
//      then gnt=1 -> master 2 granted; master 1 granted after it.
//   5. slv_r_valid_i=1 with nothing outstanding -> mst_r_valid_o=0, err_o=1, and it stays 1.
//   6. Two transactions outstanding, rst_i pulsed for 1 cycle, then r_valid
//      -> FIFO empty, no routing, err_o=1; fresh request from master 0 granted normally.

Source files
------------

// File: rtl/cluster_periph_slave_arbiter_pkg.sv
// cluster_periph_slave_arbiter_pkg: shared peripheral bus types and constants
package cluster_periph_slave_arbiter_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int PERIPH_MAX_OUTST = 2;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0] be;
  } periph_req_t;
  typedef struct packed {
    logic r_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic r_opc;
  } periph_rsp_t;
endpackage

// File: rtl/cluster_periph_slave_arbiter_if.sv
// cluster_periph_slave_arbiter_if: masters-side req/gnt/r_valid bundle plus the shared slave port
// Ports: master = requesters and slave environment driving the arbiter; slave = the arbiter's view.
interface cluster_periph_slave_arbiter_if
  import cluster_periph_slave_arbiter_pkg::*;
#(
  parameter int NB_MST = 8
);
  logic [NB_MST-1:0] mst_req;
  periph_req_t [NB_MST-1:0] mst_bus;
  logic [NB_MST-1:0] mst_gnt;
  logic [NB_MST-1:0] mst_r_valid;
  logic [DATA_WIDTH-1:0] mst_r_rdata;
  logic mst_r_opc;
  logic slv_req;
  periph_req_t slv_bus;
  logic slv_gnt;
  periph_rsp_t slv_rsp;
  modport master (
    output mst_req, mst_bus, slv_gnt, slv_rsp,
    input mst_gnt, mst_r_valid, mst_r_rdata, mst_r_opc, slv_req, slv_bus
  );
  modport slave (
    input mst_req, mst_bus, slv_gnt, slv_rsp,
    output mst_gnt, mst_r_valid, mst_r_rdata, mst_r_opc, slv_req, slv_bus
  );
endinterface

// File: rtl/cluster_periph_slave_arbiter_id_fifo.sv
// periph_id_fifo: small FIFO of granted master IDs awaiting their responses
// Ports: clk, rst, push/din, pop/dout, full, empty.
module periph_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) if (push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (push) wr <= wr == PW'(DEPTH - 1) ? '0 : wr + PW'(1);
      if (pop) rd <= rd == PW'(DEPTH - 1) ? '0 : rd + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  assign dout = mem[rd];
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
endmodule

// File: rtl/cluster_periph_slave_arbiter.sv
// cluster_periph_slave_arbiter: round-robin arbiter sharing one peripheral slave among NB_MST masters
// Ports: clk_i, rst_i (sync, active-high), bus (arbiter modport), err_o (sticky unexpected-response flag).
module cluster_periph_slave_arbiter
  import cluster_periph_slave_arbiter_pkg::*;
#(
  parameter int NB_MST = 8,
  parameter int MAX_OUTST = PERIPH_MAX_OUTST
) (
  input  logic clk_i,
  input  logic rst_i,
  cluster_periph_slave_arbiter_if.slave bus,
  output logic err_o
);
  localparam int IW = NB_MST > 1 ? $clog2(NB_MST) : 1;
  if (NB_MST < 2) begin : g_nb_mst_chk
    $error("NB_MST must be at least 2");
  end
  logic [IW-1:0] rr_ptr, lock_idx, win, idx, head;
  logic lock, any, full, empty, grant, pop;
  // Scan downwards so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = NB_MST - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % NB_MST);
      if (bus.mst_req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
    if (lock) begin
      win = lock_idx;
      any = bus.mst_req[lock_idx];
    end
  end
  assign bus.slv_req = any & ~full;
  assign bus.slv_bus = bus.mst_bus[win];
  assign grant = bus.slv_req & bus.slv_gnt;
  assign pop = bus.slv_rsp.r_valid & ~empty;
  assign bus.mst_gnt = grant ? NB_MST'(1) << win : '0;
  assign bus.mst_r_valid = pop ? NB_MST'(1) << head : '0;
  assign bus.mst_r_rdata = bus.slv_rsp.r_rdata;
  assign bus.mst_r_opc = bus.slv_rsp.r_opc;
  // The FIFO cannot grow while locked, so a stalled request is the only way lock stays set;
  // a grant or a dropped request both clear it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      lock <= 1'b0;
      lock_idx <= '0;
      err_o <= 1'b0;
    end else begin
      if (grant) rr_ptr <= win == IW'(NB_MST - 1) ? '0 : win + IW'(1);
      lock <= bus.slv_req & ~bus.slv_gnt;
      if (bus.slv_req & ~bus.slv_gnt) lock_idx <= win;
      if (bus.slv_rsp.r_valid & empty) err_o <= 1'b1;
    end
  end
  periph_id_fifo #(.DEPTH(MAX_OUTST), .WIDTH(IW)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(grant),
    .pop(pop),
    .din(win),
    .dout(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_cluster_periph_slave_arbiter.sv
// tb_cluster_periph_slave_arbiter: directed vector table plus randomized run against a queue-based model
module tb_cluster_periph_slave_arbiter;
  import cluster_periph_slave_arbiter_pkg::*;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst;
  logic err;
  int nerr = 0;
  int nchk = 0;
  cluster_periph_slave_arbiter_if #(.NB_MST(N)) bus();
  cluster_periph_slave_arbiter #(.NB_MST(N), .MAX_OUTST(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus),
    .err_o(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst;
    logic [N-1:0] req;
    logic gnt;
    logic rv;
    logic [31:0] rdata;
    logic [N-1:0] egnt;
    logic [N-1:0] erv;
    logic esreq;
    logic eerr;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(logic r, logic [N-1:0] req, logic g, logic rv, logic [31:0] rd,
                              logic [N-1:0] egnt, logic [N-1:0] erv, logic esreq, logic eerr);
    vec_t v;
    v.rst = r; v.req = req; v.gnt = g; v.rv = rv; v.rdata = rd;
    v.egnt = egnt; v.erv = erv; v.esreq = esreq; v.eerr = eerr;
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic drive(logic r, logic [N-1:0] req, logic g, logic rv, logic [31:0] rd);
    @(negedge clk);
    rst = r;
    bus.mst_req = req;
    bus.slv_gnt = g;
    bus.slv_rsp.r_valid = rv;
    bus.slv_rsp.r_rdata = rd;
    bus.slv_rsp.r_opc = rd[0];
    #2;
  endtask
  logic [31:0] adds [N];
  int q[$];
  int ptr, lidx, w;
  bit locked, merr, has, esreq;
  logic [N-1:0] req, egnt, erv;
  logic r, g, rv;
  logic [31:0] rd;
  initial begin
    rst = 1'b1;
    bus.mst_req = '0;
    bus.slv_gnt = 1'b0;
    bus.slv_rsp = '0;
    for (int i = 0; i < N; i++) begin
      adds[i] = 32'h1000_0000 + 32'(i);
      bus.mst_bus[i].add = adds[i];
      bus.mst_bus[i].wen = 1'b1;
      bus.mst_bus[i].wdata = 32'(i);
      bus.mst_bus[i].be = '1;
    end
    drive(1, '0, 0, 0, 0);
    drive(1, '0, 0, 0, 0);
    // single master 3, response a cycle later
    vecs.push_back(mk(0, 8'h08, 1, 0, 0, 8'h08, 8'h00, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 32'hCAFE0003, 8'h00, 8'h08, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    // all masters, back-to-back grant and response
    vecs.push_back(mk(0, 8'hFF, 1, 0, 0, 8'h01, 8'h00, 1, 0));
    for (int k = 1; k < N; k++)
      vecs.push_back(mk(0, 8'hFF, 1, 1, 32'(k), N'(1) << k, N'(1) << (k - 1), 1, 0));
    vecs.push_back(mk(0, 8'hFF, 1, 1, 32'h55, 8'h01, 8'h80, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 32'h66, 8'h00, 8'h01, 0, 0));
    // fill to MAX_OUTST, response in full cycle does not allow a grant
    vecs.push_back(mk(0, 8'h01, 1, 0, 0, 8'h01, 8'h00, 1, 0));
    vecs.push_back(mk(0, 8'h01, 1, 0, 0, 8'h01, 8'h00, 1, 0));
    vecs.push_back(mk(0, 8'h01, 1, 1, 32'h77, 8'h00, 8'h01, 0, 0));
    vecs.push_back(mk(0, 8'h01, 1, 0, 0, 8'h01, 8'h00, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 32'h88, 8'h00, 8'h01, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 32'h99, 8'h00, 8'h01, 0, 0));
    // stall lock on master 2 while master 1 joins
    vecs.push_back(mk(0, 8'h04, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(0, 8'h06, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(0, 8'h06, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(0, 8'h06, 1, 0, 0, 8'h04, 8'h00, 1, 0));
    vecs.push_back(mk(0, 8'h06, 1, 0, 0, 8'h02, 8'h00, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 32'hA, 8'h00, 8'h04, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 32'hB, 8'h00, 8'h02, 0, 0));
    // unexpected response: sticky error
    vecs.push_back(mk(0, 8'h00, 0, 1, 32'hC, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1));
    // reset with two outstanding, late response is unexpected
    vecs.push_back(mk(0, 8'h01, 1, 0, 0, 8'h01, 8'h00, 1, 1));
    vecs.push_back(mk(0, 8'h02, 1, 0, 0, 8'h02, 8'h00, 1, 1));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 32'hD, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 8'h01, 1, 0, 0, 8'h01, 8'h00, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 32'hE, 8'h00, 8'h01, 0, 1));
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
      chk($sformatf("v%0d gnt", i), 32'(bus.mst_gnt), 32'(vecs[i].egnt));
      chk($sformatf("v%0d r_valid", i), 32'(bus.mst_r_valid), 32'(vecs[i].erv));
      chk($sformatf("v%0d slv_req", i), 32'(bus.slv_req), 32'(vecs[i].esreq));
      chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].eerr));
      chk($sformatf("v%0d rdata", i), bus.mst_r_rdata, vecs[i].rdata);
    end
    drive(1, '0, 0, 0, 0);
    q.delete();
    ptr = 0;
    locked = 0;
    lidx = 0;
    merr = 0;
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 59) == 0;
      req = $urandom_range(0, 3) == 0 ? N'($urandom) : N'($urandom & $urandom & $urandom);
      g = $urandom_range(0, 2) != 0;
      rv = q.size() > 0 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 29) == 0;
      rd = $urandom;
      for (int i = 0; i < N; i++) begin
        adds[i] = $urandom;
        bus.mst_bus[i].add = adds[i];
      end
      drive(r, req, g, rv, rd);
      has = 0;
      w = 0;
      if (locked) begin
        has = req[lidx];
        w = lidx;
      end else
        for (int k = 0; k < N; k++)
          if (!has && req[(ptr + k) % N]) begin
            has = 1;
            w = (ptr + k) % N;
          end
      esreq = has && q.size() < 2;
      egnt = (esreq && g) ? N'(1) << w : '0;
      erv = (rv && q.size() > 0) ? N'(1) << q[0] : '0;
      chk($sformatf("r%0d gnt", c), 32'(bus.mst_gnt), 32'(egnt));
      chk($sformatf("r%0d r_valid", c), 32'(bus.mst_r_valid), 32'(erv));
      chk($sformatf("r%0d slv_req", c), 32'(bus.slv_req), 32'(esreq));
      chk($sformatf("r%0d err", c), 32'(err), 32'(merr));
      chk($sformatf("r%0d r_opc", c), 32'(bus.mst_r_opc), 32'(rd[0]));
      if (esreq) chk($sformatf("r%0d slv_add", c), bus.slv_bus.add, adds[w]);
      if (r) begin
        q.delete();
        ptr = 0;
        locked = 0;
        merr = 0;
      end else begin
        if (rv) begin
          if (q.size() > 0) void'(q.pop_front());
          else merr = 1;
        end
        if (egnt != '0) begin
          q.push_back(w);
          ptr = (w + 1) % N;
          locked = 0;
        end else if (esreq) begin
          locked = 1;
          lidx = w;
        end else if (locked && !req[lidx]) locked = 0;
      end
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
